// File: rtl/sp6_pkg.sv
// Shared constants for the sp6 board front end: clock rate, switch count
// and the derived debounce interval used by the input-conditioning stage.
package sp6_pkg;

   localparam int CLK_HZ      = 25_000_000;
   localparam int DEBOUNCE_MS = 10;
   localparam int SW_WIDTH    = 4;

   // Convert a duration in milliseconds into a count of clock cycles.
   function automatic int cycles_for_ms(input int clk_hz, input int ms);
      return (clk_hz / 1000) * ms;
   endfunction

   // Smallest counter width able to hold values 0 .. cycles-1 without wrapping.
   function automatic int cnt_width_for(input int cycles);
      return (cycles <= 2) ? 1 : $clog2(cycles);
   endfunction

   localparam int DEBOUNCE_CYCLES_DEF = cycles_for_ms(CLK_HZ, DEBOUNCE_MS);
   localparam int CNT_W_DEF           = cnt_width_for(DEBOUNCE_CYCLES_DEF);

endpackage : sp6_pkg

// File: rtl/debounce_chan.sv
// One debounced switch channel: two-flop synchroniser, stability counter,
// accepted-level flop and registered one-cycle rise/fall pulses.
module debounce_chan
   import sp6_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int CNT_W           = CNT_W_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic stable,
   output logic rise,
   output logic fall,
   output logic pulse_next
);

   // Terminal count: the synchronised level must differ for this many
   // consecutive edges (counter values 0 .. LAST) before it is accepted.
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             s1;
   logic             s2;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;
   logic             stable_next;
   logic             rise_next;
   logic             fall_next;

   // Two-stage synchroniser bringing the asynchronous pin into the clock domain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= raw;
         s2 <= s1;
      end
   end

   // Next-state decision: restart on agreement, count on disagreement,
   // accept the new level once the count reaches its terminal value.
   always_comb begin
      cnt_next    = cnt;
      stable_next = stable;
      rise_next   = 1'b0;
      fall_next   = 1'b0;
      if (s2 == stable) begin
         cnt_next = '0;
      end else if (cnt >= LAST) begin
         // ">=" keeps the counter bounded even if it were ever disturbed.
         cnt_next    = '0;
         stable_next = s2;
         rise_next   = s2;
         fall_next   = ~s2;
      end else begin
         cnt_next = cnt + CNT_W'(1);
      end
   end

   // Counter, accepted level and edge pulses, all updated together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt    <= '0;
         stable <= 1'b0;
         rise   <= 1'b0;
         fall   <= 1'b0;
      end else begin
         cnt    <= cnt_next;
         stable <= stable_next;
         rise   <= rise_next;
         fall   <= fall_next;
      end
   end

   // Lets the parent register its change flag in the same cycle as the pulses;
   // derived only from flops, so there is no path from the raw pin.
   assign pulse_next = rise_next | fall_next;

endmodule : debounce_chan

// File: rtl/switch_debounce_chk.sv
// Runtime property checks on the debouncer outputs (simulation only).
module switch_debounce_chk #(
   parameter int WIDTH = 4
) (
   input logic             clk,
   input logic             rst,
   input logic [WIDTH-1:0] sw_stable,
   input logic [WIDTH-1:0] sw_rise,
   input logic [WIDTH-1:0] sw_fall,
   input logic             any_change
);

   a_rise_fall_exclusive: assert property (@(posedge clk) disable iff (rst)
      (sw_rise & sw_fall) == '0);

   a_any_change_matches: assert property (@(posedge clk) disable iff (rst)
      any_change == |(sw_rise | sw_fall));

   a_rise_shows_high: assert property (@(posedge clk) disable iff (rst)
      (sw_rise & ~sw_stable) == '0);

   a_fall_shows_low: assert property (@(posedge clk) disable iff (rst)
      (sw_fall & sw_stable) == '0);

endmodule : switch_debounce_chk

// File: rtl/switch_debounce.sv
// Board switch conditioning: WIDTH independent synchronise-and-debounce
// channels plus a registered "something changed" flag.
module switch_debounce
   import sp6_pkg::*;
#(
   parameter int WIDTH           = SW_WIDTH,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int CNT_W           = CNT_W_DEF
) (
   input  logic             ext_clk_25m,
   input  logic             ext_rst,
   input  logic [WIDTH-1:0] sw_raw,
   output logic [WIDTH-1:0] sw_stable,
   output logic [WIDTH-1:0] sw_rise,
   output logic [WIDTH-1:0] sw_fall,
   output logic             any_change
);

   logic [WIDTH-1:0] pulse_next;

   for (genvar i = 0; i < WIDTH; i++) begin : g_chan
      debounce_chan #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W)
      ) u_chan (
         .clk        (ext_clk_25m),
         .rst        (ext_rst),
         .raw        (sw_raw[i]),
         .stable     (sw_stable[i]),
         .rise       (sw_rise[i]),
         .fall       (sw_fall[i]),
         .pulse_next (pulse_next[i])
      );
   end

   // Registered OR of all channel pulses, aligned with sw_rise/sw_fall.
   always_ff @(posedge ext_clk_25m or posedge ext_rst) begin
      if (ext_rst) begin
         any_change <= 1'b0;
      end else begin
         any_change <= |pulse_next;
      end
   end

   switch_debounce_chk #(
      .WIDTH (WIDTH)
   ) u_chk (
      .clk        (ext_clk_25m),
      .rst        (ext_rst),
      .sw_stable  (sw_stable),
      .sw_rise    (sw_rise),
      .sw_fall    (sw_fall),
      .any_change (any_change)
   );

endmodule : switch_debounce

// File: tb/tb_switch_debounce.sv
// Self-checking bench for switch_debounce with DEBOUNCE_CYCLES=4.
// Reference model: a history of sampled raw values; a channel accepts a new
// level when the DEB samples seen at the synchroniser output all differ from it.
module tb_switch_debounce;

   localparam int W   = 4;
   localparam int DEB = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [W-1:0] sw_raw = 4'hF;
   logic [W-1:0] sw_stable;
   logic [W-1:0] sw_rise;
   logic [W-1:0] sw_fall;
   logic         any_change;

   int checks   = 0;
   int failures = 0;

   logic [W-1:0] exp_stable = 4'h0;
   logic [W-1:0] exp_rise   = 4'h0;
   logic [W-1:0] exp_fall   = 4'h0;
   logic [W-1:0] hist[$];

   switch_debounce #(
      .WIDTH           (W),
      .DEBOUNCE_CYCLES (DEB),
      .CNT_W           (3)
   ) dut (
      .ext_clk_25m (clk),
      .ext_rst     (rst),
      .sw_raw      (sw_raw),
      .sw_stable   (sw_stable),
      .sw_rise     (sw_rise),
      .sw_fall     (sw_fall),
      .any_change  (any_change)
   );

   always #20 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   task automatic model_reset();
      exp_stable = 4'h0;
      exp_rise   = 4'h0;
      exp_fall   = 4'h0;
      hist.delete();
      for (int j = 0; j < DEB + 2; j++) hist.push_back(4'h0);
   endtask

   // One clock edge of the reference model (raw already sampled on this edge).
   task automatic model_edge(input logic [W-1:0] raw);
      logic [W-1:0] h;
      logic         all_diff;
      int           sz;
      exp_rise = 4'h0;
      exp_fall = 4'h0;
      hist.push_back(raw);
      sz = hist.size();
      for (int i = 0; i < W; i++) begin
         all_diff = 1'b1;
         for (int j = 2; j <= DEB + 1; j++) begin
            h = hist[sz - 1 - j];
            if (h[i] == exp_stable[i]) all_diff = 1'b0;
         end
         if (all_diff) begin
            exp_stable[i] = ~exp_stable[i];
            exp_rise[i]   = exp_stable[i];
            exp_fall[i]   = ~exp_stable[i];
         end
      end
      if (hist.size() > DEB + 6) void'(hist.pop_front());
   endtask

   task automatic compare_all();
      check_eq("sw_stable", 32'(sw_stable), 32'(exp_stable));
      check_eq("sw_rise", 32'(sw_rise), 32'(exp_rise));
      check_eq("sw_fall", 32'(sw_fall), 32'(exp_fall));
      check_eq("any_change", 32'(any_change), 32'(|(exp_rise | exp_fall)));
   endtask

   task automatic tick(input logic [W-1:0] raw, input logic rst_in);
      @(negedge clk);
      sw_raw = raw;
      rst    = rst_in;
      @(posedge clk);
      if (rst_in) model_reset();
      else        model_edge(raw);
      #1;
      compare_all();
   endtask

   task automatic hold(input logic [W-1:0] raw, input int n);
      for (int j = 0; j < n; j++) tick(raw, 1'b0);
   endtask

   // Count edges from the first one sampling the new value until bit b shows 1.
   task automatic latency(input string tag, input logic [W-1:0] raw, input int b, input int want);
      int n;
      n = 0;
      do begin
         tick(raw, 1'b0);
         n++;
      end while (!sw_stable[b] && n < 20);
      check_eq(tag, 32'(n), 32'(want));
   endtask

   initial begin
      logic [W-1:0] r;
      model_reset();
      #1;
      compare_all();

      // Reset held with all pins high.
      for (int j = 0; j < 10; j++) tick(4'hF, 1'b1);
      hold(4'h0, 8);

      // Clean rise on bit 0: accepted at edge k+5 (6th edge counting k).
      latency("rise0_latency", 4'h1, 0, 6);
      hold(4'h1, 8);

      // Three-cycle glitch on bit 1 is rejected.
      hold(4'h3, 3);
      hold(4'h1, 20);

      // Bounce on bit 2, then settle high, then clean drop.
      hold(4'h5, 2); hold(4'h1, 2); hold(4'h5, 2); hold(4'h1, 2);
      hold(4'h5, 12);
      hold(4'h1, 10);

      // Simultaneous rise of all channels from a clean reset.
      for (int j = 0; j < 3; j++) tick(4'h0, 1'b1);
      hold(4'h0, 6);
      hold(4'hF, 12);
      hold(4'h0, 12);

      // Reset mid-count on bit 3, input kept high across the reset.
      hold(4'h8, 4);
      tick(4'h8, 1'b1);
      latency("rst_midcount_latency", 4'h8, 3, 6);
      hold(4'h8, 6);

      // Randomised bouncing inputs with occasional resets.
      r = 4'h0;
      for (int j = 0; j < 3000; j++) begin
         for (int i = 0; i < W; i++)
            if ($urandom_range(5, 0) == 0) r[i] = ~r[i];
         tick(r, ($urandom_range(199, 0) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_switch_debounce
